// File: rtl/branch_resolve_execute_if.sv
// Decode-to-execute control-flow bundle: decode operands in, fetch redirect,
// link writeback and performance counters out.
interface branch_resolve_execute_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             valid_decode;
  logic [31:0]      instruction_decode;
  logic [XLEN-1:0]  pc_decode;
  logic [XLEN-1:0]  next_pc_decode;
  logic [XLEN-1:0]  rs1_data_decode;
  logic [XLEN-1:0]  rs2_data_decode;
  logic             stall_decode;
  logic             pc_select_execute;
  logic [XLEN-1:0]  pc_target_execute;
  logic             flush_decode;
  logic             link_valid_execute;
  logic [XLEN-1:0]  link_data_execute;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output valid_decode, instruction_decode, pc_decode, next_pc_decode,
           rs1_data_decode, rs2_data_decode, stall_decode,
    input  pc_select_execute, pc_target_execute, flush_decode,
           link_valid_execute, link_data_execute, branch_count, redirect_count
  );

  modport slave (
    input  valid_decode, instruction_decode, pc_decode, next_pc_decode,
           rs1_data_decode, rs2_data_decode, stall_decode,
    output pc_select_execute, pc_target_execute, flush_decode,
           link_valid_execute, link_data_execute, branch_count, redirect_count
  );
endinterface

// File: rtl/branch_resolve_execute.sv
// Execute-stage resolver for RISC-V branches, JAL and JALR: redirects fetch,
// squashes the wrong-path decode slot and counts resolved control flow.
module branch_resolve_execute #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_execute_if.slave bus
);
  typedef enum logic [1:0] {CLS_NONE, CLS_BRANCH, CLS_JAL, CLS_JALR} cf_class_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [31:0]     ins;
  logic [6:0]      dec_opcode;
  logic [2:0]      dec_funct3;
  cf_class_e       dec_cls;
  logic [XLEN-1:0] dec_imm;

  logic            ex_valid;
  cf_class_e       ex_cls;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_next_pc;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;

  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] jalr_sum;
  logic            pc_select;
  logic            link_valid;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  assign ins        = bus.instruction_decode;
  assign dec_opcode = ins[6:0];
  assign dec_funct3 = ins[14:12];

  // The immediate is selected by class in decode so execute holds only one.
  always_comb begin
    dec_cls = CLS_NONE;
    dec_imm = '0;
    case (dec_opcode)
      OP_BRANCH: begin
        if (dec_funct3 != 3'b010 && dec_funct3 != 3'b011) begin
          dec_cls = CLS_BRANCH;
          dec_imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        end
      end
      OP_JAL: begin
        dec_cls = CLS_JAL;
        dec_imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OP_JALR: begin
        if (dec_funct3 == 3'b000) begin
          dec_cls = CLS_JALR;
          dec_imm = {{20{ins[31]}}, ins[31:20]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_cls     <= CLS_NONE;
      ex_funct3  <= '0;
      ex_imm     <= '0;
      ex_pc      <= '0;
      ex_next_pc <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
    end else if (pc_select || bus.stall_decode || !bus.valid_decode) begin
      ex_valid <= 1'b0;
    end else begin
      ex_valid   <= 1'b1;
      ex_cls     <= dec_cls;
      ex_funct3  <= dec_funct3;
      ex_imm     <= dec_imm;
      ex_pc      <= bus.pc_decode;
      ex_next_pc <= bus.next_pc_decode;
      ex_rs1     <= bus.rs1_data_decode;
      ex_rs2     <= bus.rs2_data_decode;
    end
  end

  assign jalr_sum = ex_rs1 + ex_imm;

  always_comb begin
    taken  = 1'b0;
    target = ex_pc + ex_imm;
    case (ex_cls)
      CLS_BRANCH: begin
        case (ex_funct3)
          3'b000:  taken = (ex_rs1 == ex_rs2);
          3'b001:  taken = (ex_rs1 != ex_rs2);
          3'b100:  taken = ($signed(ex_rs1) <  $signed(ex_rs2));
          3'b101:  taken = ($signed(ex_rs1) >= $signed(ex_rs2));
          3'b110:  taken = (ex_rs1 <  ex_rs2);
          3'b111:  taken = (ex_rs1 >= ex_rs2);
          default: taken = 1'b0;
        endcase
      end
      CLS_JAL: taken = 1'b1;
      CLS_JALR: begin
        taken  = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: ;
    endcase
  end

  assign pc_select  = ex_valid && taken;
  assign link_valid = ex_valid && (ex_cls == CLS_JAL || ex_cls == CLS_JALR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt   <= '0;
      redirect_cnt <= '0;
    end else begin
      if (ex_valid && ex_cls != CLS_NONE && branch_cnt != '1)
        branch_cnt <= branch_cnt + 1'b1;
      if (pc_select && redirect_cnt != '1)
        redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

  assign bus.pc_select_execute  = pc_select;
  assign bus.pc_target_execute  = pc_select ? target : '0;
  assign bus.flush_decode       = pc_select;
  assign bus.link_valid_execute = link_valid;
  assign bus.link_data_execute  = link_valid ? ex_next_pc : '0;
  assign bus.branch_count       = branch_cnt;
  assign bus.redirect_count     = redirect_cnt;
endmodule

// File: tb/tb_branch_resolve_execute.sv
// Scoreboard bench for branch_resolve_execute: directed spec cases, then
// randomized traffic against an arithmetic reference model.
module tb_branch_resolve_execute;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_execute_if #(.XLEN(32), .CNT_W(CW)) bus ();
  branch_resolve_execute #(.XLEN(32), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        sel;
    logic [31:0] target;
    logic        link_v;
    logic [31:0] link_d;
    logic [31:0] bc;
    logic [31:0] rc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state: what execute currently shows, and the counters.
  logic m_sel;
  logic m_cf;
  int   m_bc;
  int   m_rc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_resolve(input logic [31:0] ins, input logic [31:0] pc,
                             input logic [31:0] r1, input logic [31:0] r2,
                             output logic cf, output logic tk,
                             output logic [31:0] tg, output logic lk);
    int b_imm, j_imm, i_imm;
    int op, f3;
    op = int'(ins[6:0]);
    f3 = int'(ins[14:12]);
    b_imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    j_imm = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    i_imm = (int'(ins[31:20]) >= 2048) ? int'(ins[31:20]) - 4096 : int'(ins[31:20]);
    cf = 1'b0; tk = 1'b0; tg = '0; lk = 1'b0;
    if (op == 'h63 && f3 != 2 && f3 != 3) begin
      cf = 1'b1;
      tg = pc + b_imm;
      case (f3)
        0: tk = (r1 == r2);
        1: tk = (r1 != r2);
        4: tk = ($signed(r1) < $signed(r2));
        5: tk = !($signed(r1) < $signed(r2));
        6: tk = (r1 < r2);
        default: tk = !(r1 < r2);
      endcase
    end else if (op == 'h6F) begin
      cf = 1'b1; tk = 1'b1; lk = 1'b1;
      tg = pc + j_imm;
    end else if (op == 'h67 && f3 == 0) begin
      cf = 1'b1; tk = 1'b1; lk = 1'b1;
      tg = (r1 + i_imm) & 32'hFFFF_FFFE;
    end
  endtask

  task automatic model_step(input logic v, input logic st, input logic [31:0] ins,
                            input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic cf, tk, lk;
    logic [31:0] tg;
    if (m_cf && m_bc < CMAX) m_bc++;
    if (m_sel && m_rc < CMAX) m_rc++;
    ref_resolve(ins, pc, r1, r2, cf, tk, tg, lk);
    if (!v || st || m_sel) begin
      cf = 1'b0; tk = 1'b0; lk = 1'b0;
    end
    e.sel    = tk;
    e.target = tk ? tg : 32'h0;
    e.link_v = lk;
    e.link_d = lk ? pc + 32'd4 : 32'h0;
    e.bc     = 32'(m_bc);
    e.rc     = 32'(m_rc);
    m_cf  = cf;
    m_sel = tk;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic v, input logic st, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clk);
    bus.valid_decode       = v;
    bus.stall_decode       = st;
    bus.instruction_decode = ins;
    bus.pc_decode          = pc;
    bus.next_pc_decode     = pc + 32'd4;
    bus.rs1_data_decode    = r1;
    bus.rs2_data_decode    = r2;
    model_step(v, st, ins, pc, r1, r2);
  endtask

  task automatic bubble();
    issue(1'b0, 1'b0, 32'h0000_0013, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic clear_inputs();
    bus.valid_decode       = 1'b0;
    bus.stall_decode       = 1'b0;
    bus.instruction_decode = '0;
    bus.pc_decode          = '0;
    bus.next_pc_decode     = '0;
    bus.rs1_data_decode    = '0;
    bus.rs2_data_decode    = '0;
  endtask

  task automatic model_reset();
    m_sel = 1'b0; m_cf = 1'b0; m_bc = 0; m_rc = 0;
    exp_q.delete();
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every cycle out of reset, the DUT's execute outputs are compared
  // against the oldest expected response.
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("sel",    32'(bus.pc_select_execute),  32'(mon_e.sel));
      chk("target", bus.pc_target_execute,       mon_e.target);
      chk("flush",  32'(bus.flush_decode),       32'(mon_e.sel));
      chk("link_v", 32'(bus.link_valid_execute), 32'(mon_e.link_v));
      chk("link_d", bus.link_data_execute,       mon_e.link_d);
      chk("bcount", 32'(bus.branch_count),       mon_e.bc);
      chk("rcount", 32'(bus.redirect_count),     mon_e.rc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ins, r1, r2;
    int sel;
    clear_inputs();
    model_reset();
    rst = 1'b1;
    #12;
    chk("rst_sel",    32'(bus.pc_select_execute),  32'h0);
    chk("rst_target", bus.pc_target_execute,       32'h0);
    chk("rst_link_v", 32'(bus.link_valid_execute), 32'h0);
    chk("rst_bcount", 32'(bus.branch_count),       32'h0);
    chk("rst_rcount", 32'(bus.redirect_count),     32'h0);
    @(negedge clk);
    rst = 1'b0;

    // BEQ taken
    issue(1'b1, 1'b0, 32'h0020_8463, 32'h10, 32'd5, 32'd5);
    after_edge();
    chk("beq_t_sel",    32'(bus.pc_select_execute), 32'h1);
    chk("beq_t_target", bus.pc_target_execute,      32'h18);
    chk("beq_t_flush",  32'(bus.flush_decode),      32'h1);
    bubble();
    after_edge();
    chk("beq_t_bc", 32'(bus.branch_count),   32'd1);
    chk("beq_t_rc", 32'(bus.redirect_count), 32'd1);

    // BEQ not taken
    issue(1'b1, 1'b0, 32'h0020_8463, 32'h10, 32'd5, 32'd6);
    after_edge();
    chk("beq_n_sel", 32'(bus.pc_select_execute), 32'h0);
    bubble();
    after_edge();
    chk("beq_n_bc", 32'(bus.branch_count),   32'd2);
    chk("beq_n_rc", 32'(bus.redirect_count), 32'd1);

    // JAL backwards
    issue(1'b1, 1'b0, 32'hFFDF_F0EF, 32'h20, 32'h0, 32'h0);
    after_edge();
    chk("jal_target", bus.pc_target_execute,       32'h1C);
    chk("jal_link_v", 32'(bus.link_valid_execute), 32'h1);
    chk("jal_link_d", bus.link_data_execute,       32'h24);
    bubble();

    // JALR clears the target LSB
    issue(1'b1, 1'b0, 32'h0050_8067, 32'h40, 32'h100, 32'h0);
    after_edge();
    chk("jalr_target", bus.pc_target_execute, 32'h104);
    bubble();
    after_edge();
    chk("jalr_bc", 32'(bus.branch_count),   32'd4);
    chk("jalr_rc", 32'(bus.redirect_count), 32'd3);

    // Back-to-back taken branches: the second is squashed
    issue(1'b1, 1'b0, 32'h0020_8463, 32'h10, 32'd7, 32'd7);
    issue(1'b1, 1'b0, 32'h0020_8463, 32'h14, 32'd7, 32'd7);
    after_edge();
    chk("squash_sel", 32'(bus.pc_select_execute), 32'h0);
    bubble();
    after_edge();
    chk("squash_bc", 32'(bus.branch_count),   32'd5);
    chk("squash_rc", 32'(bus.redirect_count), 32'd4);

    // Stall inserts a bubble
    issue(1'b1, 1'b1, 32'h0020_8463, 32'h10, 32'd5, 32'd5);
    after_edge();
    chk("stall_sel", 32'(bus.pc_select_execute), 32'h0);
    bubble();
    after_edge();
    chk("stall_bc", 32'(bus.branch_count),   32'd5);
    chk("stall_rc", 32'(bus.redirect_count), 32'd4);

    // Reset while a taken BEQ is in execute
    issue(1'b1, 1'b0, 32'h0020_8463, 32'h10, 32'd5, 32'd5);
    after_edge();
    chk("pre_rst_sel", 32'(bus.pc_select_execute), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sel",    32'(bus.pc_select_execute),  32'h0);
    chk("mid_rst_target", bus.pc_target_execute,       32'h0);
    chk("mid_rst_flush",  32'(bus.flush_decode),       32'h0);
    chk("mid_rst_link_v", 32'(bus.link_valid_execute), 32'h0);
    chk("mid_rst_bc",     32'(bus.branch_count),       32'h0);
    chk("mid_rst_rc",     32'(bus.redirect_count),     32'h0);
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic; small counters reach saturation
    repeat (600) begin
      ins = $urandom;
      sel = int'($urandom_range(0, 5));
      if (sel <= 2) ins[6:0] = 7'b1100011;
      else if (sel == 3) ins[6:0] = 7'b1101111;
      else if (sel == 4) begin
        ins[6:0] = 7'b1100111;
        if ($urandom_range(0, 3) != 0) ins[14:12] = 3'b000;
      end
      r1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      case ($urandom_range(0, 3))
        0: r2 = r1;
        1: r2 = ~r1;
        2: r2 = 32'($urandom_range(0, 3));
        default: r2 = $urandom;
      endcase
      issue($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, ins,
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, r1, r2);
    end
    bubble();
    bubble();
    for (int unsigned k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    chk("drain", 32'(exp_q.size()), 32'h0);
    chk("sat_bc", 32'(bus.branch_count),   32'(m_bc));
    chk("sat_rc", 32'(bus.redirect_count), 32'(m_rc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
